// File: rtl/wts_channel_mixer.sv
// Five-channel volume mixer: scales each channel's wave-RAM sample by its volume,
// sums channels A..E per 8-slot frame and emits one saturated sample per frame.
module wts_channel_mixer #(
  parameter int OUT_WIDTH = 11,
  parameter int SHIFT     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           active,
  input  logic [7:0]           sample_data,
  input  logic [3:0]           reg_volume_a,
  input  logic [3:0]           reg_volume_b,
  input  logic [3:0]           reg_volume_c,
  input  logic [3:0]           reg_volume_d,
  input  logic [3:0]           reg_volume_e,
  input  logic [4:0]           reg_enable,
  output logic [OUT_WIDTH-1:0] sound_out,
  output logic                 sound_valid
);

  localparam logic signed [14:0] OUT_MAX = 15'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [14:0] OUT_MIN = 15'(-(1 << (OUT_WIDTH-1)));

  logic [2:0]           ch_d1_q;
  logic                 slot_v_q;
  logic signed [11:0]   prod_d, prod_q;
  logic [2:0]           prod_ch_q;
  logic                 prod_v_q;
  logic signed [14:0]   acc_q, acc_d, prod_ext, sum_sh;
  logic                 frame_ok_q;
  logic [OUT_WIDTH-1:0] sound_out_q, sat_d;
  logic                 sound_valid_q;
  logic [3:0]           vol_sel;
  logic                 en_sel;

  // Idle slots 5..7 select no channel, so their product is forced to zero.
  always_comb begin
    vol_sel = '0;
    en_sel  = 1'b0;
    case (ch_d1_q)
      3'd0: begin vol_sel = reg_volume_a; en_sel = reg_enable[0]; end
      3'd1: begin vol_sel = reg_volume_b; en_sel = reg_enable[1]; end
      3'd2: begin vol_sel = reg_volume_c; en_sel = reg_enable[2]; end
      3'd3: begin vol_sel = reg_volume_d; en_sel = reg_enable[3]; end
      3'd4: begin vol_sel = reg_volume_e; en_sel = reg_enable[4]; end
      default: ;
    endcase
  end

  // slot_v_q masks the first cycle after reset: ch_d1_q then holds a reset
  // value, not a real slot, and must not be taken as a ch A product.
  assign prod_d = (slot_v_q && en_sel)
                ? $signed({{4{sample_data[7]}}, sample_data}) * $signed({8'd0, vol_sel})
                : '0;

  assign prod_ext = {{3{prod_q[11]}}, prod_q};
  assign acc_d    = (prod_ch_q == 3'd0) ? prod_ext : acc_q + prod_ext;
  assign sum_sh   = acc_d >>> SHIFT;

  always_comb begin
    if (sum_sh > OUT_MAX)      sat_d = OUT_MAX[OUT_WIDTH-1:0];
    else if (sum_sh < OUT_MIN) sat_d = OUT_MIN[OUT_WIDTH-1:0];
    else                       sat_d = sum_sh[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_d1_q       <= '0;
      slot_v_q      <= 1'b0;
      prod_q        <= '0;
      prod_ch_q     <= '0;
      prod_v_q      <= 1'b0;
      acc_q         <= '0;
      frame_ok_q    <= 1'b0;
      sound_out_q   <= '0;
      sound_valid_q <= 1'b0;
    end else begin
      ch_d1_q       <= active;
      slot_v_q      <= 1'b1;
      prod_q        <= prod_d;
      prod_ch_q     <= ch_d1_q;
      prod_v_q      <= slot_v_q && (ch_d1_q <= 3'd4);
      sound_valid_q <= 1'b0;
      if (prod_v_q) begin
        acc_q <= acc_d;
        if (prod_ch_q == 3'd0) frame_ok_q <= 1'b1;
        if (prod_ch_q == 3'd4 && frame_ok_q) begin
          sound_out_q   <= sat_d;
          sound_valid_q <= 1'b1;
        end
      end
    end
  end

  assign sound_out   = sound_out_q;
  assign sound_valid = sound_valid_q;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Self-checking bench for wts_channel_mixer: directed frames plus randomized traffic
// compared cycle by cycle against a frame-sum reference model.
module tb_wts_channel_mixer;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    active = '0;
  logic [7:0]    sample_data = '0;
  logic [3:0]    va = '0, vb = '0, vc = '0, vd = '0, ve = '0;
  logic [4:0]    en = '0;
  logic [OW-1:0] sound_out;
  logic          sound_valid;

  always #5 clk = ~clk;

  wts_channel_mixer #(.OUT_WIDTH(OW), .SHIFT(3)) dut (
    .clk(clk), .reset(reset), .active(active), .sample_data(sample_data),
    .reg_volume_a(va), .reg_volume_b(vb), .reg_volume_c(vc),
    .reg_volume_d(vd), .reg_volume_e(ve), .reg_enable(en),
    .sound_out(sound_out), .sound_valid(sound_valid)
  );

  int ntot = 0, npass = 0;
  int nstrobe = 0;
  bit inorder = 1'b1;
  logic [OW-1:0] last_strobe = '0;

  // reference model: per-frame weighted sum of the samples seen one cycle after each slot
  int m_acc = 0, m_pval = 0;
  bit m_have0 = 0, m_pend = 0, m_v = 0, m_prst = 1;
  logic [OW-1:0] m_out = '0;
  logic [2:0] m_pact = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int vol_of(input logic [2:0] ch);
    case (ch)
      3'd0: return int'(va);
      3'd1: return int'(vb);
      3'd2: return int'(vc);
      3'd3: return int'(vd);
      default: return int'(ve);
    endcase
  endfunction

  function automatic int sat(input int v);
    if (v > 1023) return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic logic [OW-1:0] s11(input int v);
    return v[OW-1:0];
  endfunction

  task automatic model_edge();
    int c;
    logic signed [14:0] w;
    if (reset) begin
      m_out = '0; m_v = 0; m_pend = 0; m_have0 = 0; m_acc = 0;
    end else begin
      m_v = m_pend;
      if (m_pend) m_out = s11(m_pval);
      m_pend = 0;
      if (!m_prst && m_pact <= 3'd4) begin
        c = en[m_pact] ? $signed(sample_data) * vol_of(m_pact) : 0;
        if (m_pact == 3'd0) begin m_acc = c; m_have0 = 1; end
        else m_acc = m_acc + c;
        w = m_acc[14:0];
        m_acc = int'(w);
        if (m_pact == 3'd4 && m_have0) begin
          m_pend = 1;
          m_pval = sat(m_acc >>> 3);
        end
      end
    end
    m_pact = active;
    m_prst = reset;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", 32'(sound_valid), 32'(m_v));
    chk("out", 32'(sound_out), 32'(m_out));
    if (sound_valid) begin
      nstrobe++;
      last_strobe = sound_out;
      if (inorder) chk("strobe_slot", 32'(active), 32'd6);
    end
    active = active + 3'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_all(input logic [3:0] v, input logic [4:0] e, input logic [7:0] s);
    va = v; vb = v; vc = v; vd = v; ve = v; en = e; sample_data = s;
  endtask

  initial begin
    // reset held while slots cycle
    set_all(4'd15, 5'h1f, 8'h55);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_data = 8'($urandom);
      cyc();
      chk("rst_out", 32'(sound_out), 32'd0);
      chk("rst_valid", 32'(sound_valid), 32'd0);
    end
    reset = 1'b0;

    // all channels, vol 15, sample 0x10
    set_all(4'd15, 5'h1f, 8'h10);
    run(16);
    nstrobe = 0;
    run(24);
    chk("t2_count", 32'(nstrobe), 32'd3);
    chk("t2_value", 32'(last_strobe), 32'(s11(150)));

    // only A enabled
    set_all(4'd15, 5'h01, 8'h80);
    run(24);
    chk("t3_neg", 32'(last_strobe), 32'(s11(-240)));
    va = 4'd0;
    run(24);
    chk("t3_vol0", 32'(last_strobe), 32'd0);
    va = 4'd15; en = 5'h00;
    run(24);
    chk("t3_en0", 32'(last_strobe), 32'd0);

    // saturation both ways
    set_all(4'd15, 5'h1f, 8'h7f);
    run(24);
    chk("t4_pos", 32'(last_strobe), 32'(s11(1023)));
    sample_data = 8'h80;
    run(24);
    chk("t4_neg", 32'(last_strobe), 32'(s11(-1024)));

    // vol C cleared in the active==1 cycle
    set_all(4'd15, 5'h1f, 8'h10);
    run(16);
    while (active != 3'd1) cyc();
    vc = 4'd0;
    nstrobe = 0;
    run(8);
    chk("t5_count", 32'(nstrobe), 32'd1);
    chk("t5_value", 32'(last_strobe), 32'(s11(120)));

    // reset pulse in an active==2 cycle
    set_all(4'd15, 5'h1f, 8'h7f);
    run(16);
    while (active != 3'd2) cyc();
    reset = 1'b1;
    cyc();
    chk("t6_rst_out", 32'(sound_out), 32'd0);
    reset = 1'b0;
    sample_data = 8'h10;
    nstrobe = 0;
    run(5);
    chk("t6_no_strobe", 32'(nstrobe), 32'd0);
    run(8);
    chk("t6_count", 32'(nstrobe), 32'd1);
    chk("t6_value", 32'(last_strobe), 32'(s11(150)));

    // random in-order traffic with register writes at arbitrary points
    for (int i = 0; i < 400; i++) begin
      sample_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        va = 4'($urandom); vb = 4'($urandom); vc = 4'($urandom);
        vd = 4'($urandom); ve = 4'($urandom); en = 5'($urandom);
      end
      cyc();
    end

    // out-of-order slots with sporadic resets
    inorder = 1'b0;
    for (int i = 0; i < 300; i++) begin
      active = 3'($urandom);
      sample_data = 8'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        va = 4'($urandom); ve = 4'($urandom); en = 5'($urandom);
      end
      cyc();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
